// File: rtl/microseq_control.sv
// microseq_control: microcoded sequencer with a loadable control store,
// an opcode dispatch table, wait-on-memory stalls and a timeout trap.
module microseq_control #(
  parameter int                 OPC_W    = 4,
  parameter int                 CW_W     = 32,
  parameter int                 UADDR_W  = 6,
  parameter logic [UADDR_W-1:0] TRAP_VEC = 6'h3C,
  parameter int                 PRIV_BIT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OPC_W-1:0]        opcode,
  input  logic [3:0]              cond,
  input  logic                    mem_ready,
  input  logic                    timeout,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [UADDR_W-1:0]      ld_addr,
  input  logic [CW_W+UADDR_W+4:0] ld_data,
  output logic [CW_W-1:0]         ctrl,
  output logic [UADDR_W-1:0]      upc,
  output logic [1:0]              state,
  output logic                    trap
);

  localparam int MW_W   = CW_W + UADDR_W + 5;
  localparam int UDEPTH = 1 << UADDR_W;
  localparam int DDEPTH = 1 << OPC_W;
  localparam int NX_LSB = CW_W;
  localparam int CS_LSB = CW_W + UADDR_W;
  localparam int SQ_LSB = CW_W + UADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SQ_NEXT  = 3'd0,
    SQ_JUMP  = 3'd1,
    SQ_DISP  = 3'd2,
    SQ_CJUMP = 3'd3,
    SQ_FEND  = 3'd4,
    SQ_WAIT  = 3'd5,
    SQ_HALT  = 3'd6,
    SQ_RSVD  = 3'd7
  } seq_e;

  // Neither array is reset: contents are only meaningful once loaded.
  logic [MW_W-1:0]    store_q [UDEPTH];
  logic [UADDR_W-1:0] disp_q  [DDEPTH];

  state_e             state_q;
  logic [UADDR_W-1:0] upc_q;
  logic               trap_q;

  logic [MW_W-1:0]    uword;
  logic [CW_W-1:0]    u_ctrl;
  logic [UADDR_W-1:0] u_next;
  logic [1:0]         u_csel;
  seq_e               u_seq;
  logic [UADDR_W-1:0] upc_inc;
  logic               busy;
  logic               ld_ok;
  logic               trap_hit;

  assign uword    = store_q[upc_q];
  assign u_ctrl   = uword[CW_W-1:0];
  assign u_next   = uword[NX_LSB +: UADDR_W];
  assign u_csel   = uword[CS_LSB +: 2];
  assign u_seq    = seq_e'(uword[SQ_LSB +: 3]);
  assign upc_inc  = upc_q + UADDR_W'(1);
  assign busy     = (state_q == S_RUN) || (state_q == S_WAIT);
  assign ld_ok    = ld_en && !busy && !reset;
  assign trap_hit = timeout && !cond[PRIV_BIT];

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      if (ld_sel)
        disp_q[ld_addr[OPC_W-1:0]] <= ld_data[UADDR_W-1:0];
      else
        store_q[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q <= S_RUN;
            upc_q   <= '0;
          end
        end
        S_RUN: begin
          unique case (u_seq)
            SQ_NEXT:  upc_q <= upc_inc;
            SQ_JUMP:  upc_q <= u_next;
            SQ_DISP:  upc_q <= disp_q[opcode];
            SQ_CJUMP: upc_q <= cond[u_csel] ? u_next : upc_inc;
            SQ_FEND: begin
              if (trap_hit) begin
                upc_q  <= TRAP_VEC;
                trap_q <= 1'b1;
              end else begin
                upc_q  <= '0;
              end
            end
            SQ_WAIT: begin
              // Ready on the first cycle is a plain step, no stall.
              if (mem_ready)
                upc_q <= upc_inc;
              else
                state_q <= S_WAIT;
            end
            SQ_HALT, SQ_RSVD: state_q <= S_HALT;
          endcase
        end
        S_WAIT: begin
          if (mem_ready) begin
            state_q <= S_RUN;
            upc_q   <= upc_inc;
          end
        end
      endcase
    end
  end

  assign ctrl  = busy ? u_ctrl : '0;
  assign upc   = upc_q;
  assign state = state_q;
  assign trap  = trap_q;

endmodule

// File: tb/tb_microseq_control.sv
// Scoreboard bench for microseq_control: directed scenarios plus random
// programs, checked against a cycle-level reference model.
module tb_microseq_control;

  localparam int MW = 43;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    opcode;
  logic [3:0]    cond;
  logic          mem_ready;
  logic          timeout;
  logic          ld_en;
  logic          ld_sel;
  logic [5:0]    ld_addr;
  logic [MW-1:0] ld_data;
  logic [31:0]   ctrl;
  logic [5:0]    upc;
  logic [1:0]    state;
  logic          trap;

  always #5 clk = ~clk;

  microseq_control dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .cond      (cond),
    .mem_ready (mem_ready),
    .timeout   (timeout),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ctrl      (ctrl),
    .upc       (upc),
    .state     (state),
    .trap      (trap)
  );

  typedef struct {
    bit          rst;
    bit          st;
    bit          mr;
    bit          to;
    bit          le;
    bit          ls;
    bit [3:0]    opc;
    bit [3:0]    cnd;
    bit [5:0]    la;
    bit [MW-1:0] ld;
  } stim_t;

  typedef struct {
    int        st;
    int        upc;
    bit [31:0] ctrl;
    bit        trap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: state numbers as named by the block's interface.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  bit [MW-1:0] m_store [64];
  int          m_disp  [16];
  int          m_st    = M_IDLE;
  int          m_upc   = 0;
  bit          m_trap  = 1'b0;

  function automatic bit [MW-1:0] mw(input int sq, input int cs,
                                     input int nx, input bit [31:0] cw);
    bit [2:0] s3;
    bit [1:0] c2;
    bit [5:0] n6;
    s3 = 3'(sq);
    c2 = 2'(cs);
    n6 = 6'(nx);
    return {s3, c2, n6, cw};
  endfunction

  task automatic model_step(input stim_t s);
    bit [MW-1:0] w;
    int nx, cs, sq;
    if (s.rst) begin
      m_st   = M_IDLE;
      m_upc  = 0;
      m_trap = 1'b0;
      return;
    end
    m_trap = 1'b0;
    if ((m_st == M_IDLE || m_st == M_HALT) && s.le) begin
      if (s.ls) m_disp[s.la % 16] = int'(s.ld % 64);
      else      m_store[s.la] = s.ld;
    end
    w  = m_store[m_upc];
    nx = int'(w[37:32]);
    cs = int'(w[39:38]);
    sq = int'(w[42:40]);
    case (m_st)
      M_IDLE, M_HALT: begin
        if (s.st) begin
          m_st  = M_RUN;
          m_upc = 0;
        end
      end
      M_RUN: begin
        case (sq)
          0: m_upc = (m_upc + 1) % 64;
          1: m_upc = nx;
          2: m_upc = m_disp[s.opc];
          3: m_upc = s.cnd[cs] ? nx : (m_upc + 1) % 64;
          4: begin
            if (s.to && !s.cnd[2]) begin
              m_upc  = 'h3C;
              m_trap = 1'b1;
            end else begin
              m_upc = 0;
            end
          end
          5: begin
            if (s.mr) m_upc = (m_upc + 1) % 64;
            else      m_st = M_WAIT;
          end
          default: m_st = M_HALT;
        endcase
      end
      M_WAIT: begin
        if (s.mr) begin
          m_st  = M_RUN;
          m_upc = (m_upc + 1) % 64;
        end
      end
      default: ;
    endcase
  endtask

  function automatic stim_t idle(input bit [3:0] cnd, input bit mr,
                                 input bit to, input bit [3:0] opc);
    stim_t s;
    s = '{default: '0};
    s.cnd = cnd;
    s.mr  = mr;
    s.to  = to;
    s.opc = opc;
    return s;
  endfunction

  task automatic cyc(input stim_t s);
    exp_t e;
    @(negedge clk);
    reset     = s.rst;
    start     = s.st;
    mem_ready = s.mr;
    timeout   = s.to;
    ld_en     = s.le;
    ld_sel    = s.ls;
    opcode    = s.opc;
    cond      = s.cnd;
    ld_addr   = s.la;
    ld_data   = s.ld;
    model_step(s);
    e.st   = m_st;
    e.upc  = m_upc;
    e.ctrl = (m_st == M_RUN || m_st == M_WAIT) ? m_store[m_upc][31:0] : 32'h0;
    e.trap = m_trap;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit [3:0] cnd, input bit mr,
                     input bit to, input bit [3:0] opc);
    for (int i = 0; i < n; i++) cyc(idle(cnd, mr, to, opc));
  endtask

  task automatic ld(input bit sel, input int addr, input bit [MW-1:0] d);
    stim_t s;
    s    = idle(4'h0, 1'b0, 1'b0, 4'h0);
    s.le = 1'b1;
    s.ls = sel;
    s.la = 6'(addr);
    s.ld = d;
    cyc(s);
  endtask

  task automatic go(input bit [3:0] cnd, input bit [3:0] opc);
    stim_t s;
    s    = idle(cnd, 1'b0, 1'b0, opc);
    s.st = 1'b1;
    cyc(s);
  endtask

  task automatic rst_cyc();
    stim_t s;
    s     = idle(4'h0, 1'b0, 1'b0, 4'h0);
    s.rst = 1'b1;
    cyc(s);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("upc", 32'(upc), 32'(e.upc));
        chk("ctrl", ctrl, e.ctrl);
        chk("trap", 32'(trap), 32'(e.trap));
      end
    end
  end

  function automatic bit [MW-1:0] rword();
    bit [63:0] r;
    r = {$urandom, $urandom};
    return r[MW-1:0];
  endfunction

  initial begin
    stim_t s;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; timeout = 1'b0;
    ld_en = 1'b0; ld_sel = 1'b0; opcode = '0; cond = '0;
    ld_addr = '0; ld_data = '0;

    rst_cyc();
    rst_cyc();
    for (int i = 0; i < 64; i++) ld(1'b0, i, mw(6, 0, 0, 32'hA500_0000 + i));
    for (int j = 0; j < 16; j++) ld(1'b1, j, MW'((j * 5) % 64));

    // Dispatch path: 0 -> 1 -> dispatch[5]=0x10 -> fetch end -> 0
    ld(1'b0, 0, mw(0, 0, 0, 32'h11));
    ld(1'b0, 1, mw(2, 0, 0, 32'h22));
    ld(1'b1, 5, MW'('h10));
    ld(1'b0, 'h10, mw(4, 0, 0, 32'h44));
    go(4'h0, 4'h5);
    run(4, 4'h0, 1'b0, 1'b0, 4'h5);
    rst_cyc();

    // Conditional jump taken / not taken
    ld(1'b0, 0, mw(1, 0, 'h10, 32'h55));
    ld(1'b0, 'h10, mw(3, 0, 'h20, 32'h33));
    ld(1'b0, 'h20, mw(6, 0, 0, 32'h2020));
    ld(1'b0, 'h11, mw(7, 0, 0, 32'h1111));
    go(4'h1, 4'h0);
    run(3, 4'h1, 1'b0, 1'b0, 4'h0);
    go(4'h0, 4'h0);
    run(3, 4'h0, 1'b0, 1'b0, 4'h0);

    // Memory wait: three stalled cycles, then release; then no-stall case
    ld(1'b0, 0, mw(1, 0, 8, 32'h66));
    ld(1'b0, 8, mw(5, 0, 0, 32'h88));
    ld(1'b0, 9, mw(6, 0, 0, 32'h99));
    go(4'h0, 4'h0);
    run(4, 4'h0, 1'b0, 1'b0, 4'h0);
    run(2, 4'h0, 1'b1, 1'b0, 4'h0);
    go(4'h0, 4'h0);
    run(3, 4'h0, 1'b1, 1'b0, 4'h0);

    // Reset in WAIT; loads ignored while busy
    go(4'h0, 4'h0);
    run(3, 4'h0, 1'b0, 1'b0, 4'h0);
    rst_cyc();
    go(4'h0, 4'h0);
    ld(1'b0, 8, mw(5, 0, 0, 32'hDEAD));
    ld(1'b0, 8, mw(6, 0, 0, 32'hBEEF));
    ld(1'b1, 5, MW'('h2A));
    run(2, 4'h0, 1'b0, 1'b0, 4'h0);
    run(3, 4'h0, 1'b1, 1'b0, 4'h0);

    // Timeout trap unprivileged, then suppressed when privileged
    ld(1'b0, 0, mw(4, 0, 0, 32'h77));
    ld(1'b0, 'h3C, mw(6, 0, 0, 32'h3C3C));
    go(4'h0, 4'h0);
    run(2, 4'h0, 1'b0, 1'b1, 4'h0);
    rst_cyc();
    go(4'h4, 4'h0);
    run(2, 4'h4, 1'b0, 1'b1, 4'h0);
    rst_cyc();

    // Load and start together in IDLE
    s    = idle(4'h0, 1'b0, 1'b0, 4'h0);
    s.st = 1'b1; s.le = 1'b1; s.la = 6'h0; s.ld = mw(6, 0, 0, 32'h9999);
    cyc(s);
    run(2, 4'h0, 1'b0, 1'b0, 4'h0);

    // Micro-PC wrap at the top of the store
    ld(1'b0, 0, mw(1, 0, 'h3F, 32'h12));
    ld(1'b0, 'h3F, mw(0, 0, 0, 32'h3F3F));
    go(4'h0, 4'h0);
    run(3, 4'h0, 1'b0, 1'b0, 4'h0);
    rst_cyc();

    // Random programs and random inputs
    for (int i = 0; i < 64; i++) ld(1'b0, i, rword());
    for (int j = 0; j < 16; j++) ld(1'b1, j, rword());
    for (int k = 0; k < 3000; k++) begin
      s.rst = ($urandom % 64) == 0;
      s.st  = ($urandom % 4) == 0;
      s.mr  = ($urandom % 3) != 0;
      s.to  = 1'($urandom);
      s.le  = ($urandom % 4) == 0;
      s.ls  = 1'($urandom);
      s.opc = 4'($urandom);
      s.cnd = 4'($urandom);
      s.la  = 6'($urandom);
      s.ld  = rword();
      cyc(s);
    end
    run(2, 4'h0, 1'b0, 1'b0, 4'h0);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microseq_control.md
MICROSEQ_CONTROL -- requirements
Module: microseq_control

Interface
REQ-001 Parameter OPC_W, default 4, opcode width; dispatch table depth 2^OPC_W.
REQ-002 Parameter CW_W, default 32, control-word width driven to datapath.
REQ-003 Parameter UADDR_W, default 6, micro-PC width; microcode depth 2^UADDR_W.
REQ-004 Parameter TRAP_VEC, default 6'h3C, micro-address entered on timeout trap; PRIV_BIT, default 2, index of privilege flag in cond.
REQ-005 Clock and reset: clk, reset; reset is synchronous, active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  leave IDLE and begin execution at micro-address 0.
REQ-009 opcode  in  OPC_W  instruction opcode used by DISPATCH.
REQ-010 cond  in  4  flags: [0] Z, [1] N, [2] privileged, [3] spare.
REQ-011 mem_ready  in  1  memory handshake, completes WAIT microinstructions.
REQ-012 timeout  in  1  level timer expiry, sampled only at FETCH_END.
REQ-013 ld_en, ld_sel  in  1,1  load strobe; ld_sel 0 = microcode store, 1 = dispatch table.
REQ-014 ld_addr  in  UADDR_W  load address (dispatch uses low OPC_W bits); ld_data in CW_W+UADDR_W+5 load word (dispatch uses low UADDR_W bits).
REQ-015 ctrl  out  CW_W  control word; upc  out  UADDR_W  micro-PC; state  out  2  FSM state; trap  out  1  trap-taken pulse.

Function
REQ-016 Microword layout LSB first: ctrl[CW_W], next[UADDR_W], csel[2], seq[3].
REQ-017 FSM states: IDLE=0, RUN=1, WAIT=2, HALT=3; IDLE->RUN on start, upc<=0.
REQ-018 In RUN/WAIT ctrl = ctrl field of store[upc] combinationally; in IDLE/HALT ctrl = 0.
REQ-019 seq 0 NEXT: upc<=upc+1, wraps 2^UADDR_W-1 -> 0.
REQ-020 seq 1 JUMP: upc<=next.
REQ-021 seq 2 DISPATCH: upc<=dispatch[opcode].
REQ-022 seq 3 CJUMP: upc<=next if cond[csel]=1, else upc+1.
REQ-023 seq 4 FETCH_END: if timeout=1 and cond[PRIV_BIT]=0, upc<=TRAP_VEC and trap=1 for exactly that one cycle (registered, asserted the cycle after); else upc<=0.
REQ-024 seq 5 WAIT: RUN->WAIT if mem_ready=0, upc held, ctrl held asserted; WAIT->RUN with upc+1 the cycle mem_ready=1; mem_ready=1 in the first cycle gives no WAIT entry (single-cycle step).
REQ-025 seq 6 HALT: ->HALT, upc held; HALT->RUN on start with upc<=0.
REQ-026 seq 7 reserved: treated as HALT.
REQ-027 Loads write on ld_en only in IDLE or HALT; ignored in RUN/WAIT; one write per cycle.
REQ-028 start in RUN/WAIT ignored; start and ld_en same cycle in IDLE: load performed and run begins, the loaded word visible if address 0.
REQ-029 Microcode store and dispatch table are not cleared by reset; contents undefined until loaded.

Reset
REQ-030 On reset: state=IDLE, upc=0, trap=0, ctrl=0 the following cycle, regardless of current state including mid-WAIT.
REQ-031 reset has priority over start, ld_en and all sequencing.

Verification
REQ-032 Load store[0]=NEXT ctrl 0x11, store[1]=DISPATCH, dispatch[5]=0x10, store[0x10]=FETCH_END; opcode=5, start -> upc 0,1,0x10,0 ctrl 0x11 at upc 0.
REQ-033 store[0x10]=CJUMP csel=0 next=0x20; cond=0001 -> upc 0x20; cond=0000 -> upc 0x11.
REQ-034 WAIT at 0x08, mem_ready low 3 cycles -> state=WAIT 3 cycles, upc=0x08, ctrl unchanged; then upc=0x09.
REQ-035 FETCH_END with timeout=1, cond=0000 -> upc=0x3C, trap pulses 1 cycle; cond=0100 -> upc=0, trap=0.
REQ-036 Reset asserted during WAIT -> next cycle state=IDLE, upc=0, ctrl=0; ld_en during RUN leaves store unchanged.
REQ-037 NEXT at upc=0x3F -> upc=0x00; HALT word -> state=3, ctrl=0, start restarts at 0.
